rc5_scheduler: RTL and testbench
================================

// Module: rc5_scheduler
// PURPOSE
//  Sequencer and arbiter for the RC5 core. Runs key expansion once per key, then takes block requests over a
//  valid/ready handshake and dispatches each one to the encrypt engine (and, optionally, the decrypt engine).
//  Holds the engine's level-sensitive start, captures the result and presents it downstream.
//  Owns the shared S-table read address: muxes the key, encrypt and decrypt address ports onto one table.
// PARAMETERS
//  W         32                word width (16/32/64 selects the barrel shifter variant in the engines)
//  R         12                number of rounds
//  T_LENGTH  $clog2(2*(R+1))   S-table address width (derived, do not override)
// PORTS
//  clk             in   1         clock
//  rst             in   1         reset, asynchronous, active-low
//  iKey_req        in   1         pulse: (re)expand key
//  oKey_start      out  1         start to key engine, held high until iKey_done
//  iKey_done       in   1         key engine finished
//  oKey_valid      out  1         S table holds a valid schedule
//  iValid/oReady   in/out 1       input handshake
//  iMode           in   1         0 = encrypt, 1 = decrypt
//  iA, iB          in   W         input block
//  oEng_A, oEng_B  out  W         registered block to engines, stable while start is high
//  oStart_enc      out  1         encrypt engine start (level)
//  oStart_dec      out  1         decrypt engine start (level)
//  iEnc_done       in   1         encrypt engine done
//  iDec_done       in   1         decrypt engine done
//  iEnc_A/B        in   W         encrypt engine result
//  iDec_A/B        in   W         decrypt engine result
//  iKey_addr1/2    in   T_LENGTH  key engine S address
//  iEnc_addr1/2    in   T_LENGTH  encrypt engine S address
//  iDec_addr1/2    in   T_LENGTH  decrypt engine S address
//  oS_address1/2   out  T_LENGTH  muxed S-table address
//  oValid/iReady   out/in 1       output handshake
//  oA, oB          out  W         result block
// BEHAVIOUR
//  Reset (async, rst=0): state NO_KEY; all outputs 0 except oS_address2=1.
//  States:
//   NO_KEY  -> KEY_EXP on iKey_req.
//   KEY_EXP -> READY on iKey_done (oKey_valid set the next cycle).
//   READY   -> RUN_ENC or RUN_DEC on iValid&oReady (iA/iB latched into oEng_A/B); -> KEY_EXP on iKey_req.
//   RUN_x   -> DONE on iX_done (iX_A/B latched into oA/oB).
//   DONE    -> READY, or KEY_EXP if a key request is pending, on oValid&iReady.
//  oKey_start=1 only in KEY_EXP; oStart_x=1 only in RUN_x. Start is low for >=1 cycle between operations,
//   which guarantees an engine reset.
//  oReady=1 only in READY with no pending key request. oValid=1 only in DONE; oA/oB stable until accepted.
//  Latency: accept at cycle t -> start high at t+1 -> result captured at cycle after iX_done -> oValid.
//  Address mux: KEY_EXP selects key, RUN_DEC selects dec, all other states select enc.
//  iKey_req during RUN_x/DONE: latched as pending and serviced after DONE; oKey_valid clears on entry to KEY_EXP.
//  iKey_req during KEY_EXP: ignored (no restart).
//  iValid in NO_KEY/KEY_EXP: not accepted (oReady=0).
//  Spurious iX_done outside RUN_x: ignored.
//  Simultaneous iKey_req and iValid in READY: key request wins, block not accepted.
//  Reset mid-operation: everything drops immediately; start low aborts the engines; the key must be re-expanded.
// CONFIGURATION
//  RC5_DECRYPT_EN defined: iMode honoured; RUN_DEC and the dec ports are live.
//  RC5_DECRYPT_EN undefined: iMode ignored, every block is encrypted; oStart_dec tied 0; iDec_* unused;
//   RUN_DEC state not generated.
// STRUCTURE
//  rc5_pkg: state encodings (`NO_KEY .. DONE`), MODE_ENC/MODE_DEC, T/T_LENGTH functions of W/R.
//  Sub-module rc5_s_addr_mux: combinational 3:1 mux for the S address pair, selected from state.
// TESTING
//  1. rst=0 then 1, iValid=1 -> oReady stays 0, oKey_valid=0, no start asserted.
//  2. iKey_req, key engine done after 10 cycles -> oKey_start high exactly until iKey_done; oKey_valid=1 next cycle.
//  3. Zero 16-byte key, iA=0, iB=0, iMode=0 -> oA=32'hEEDBA521, oB=32'h6D8F4B15 with oValid; holds 5 cycles under
//     iReady=0.
//  4. RC5_DECRYPT_EN: feed test 3 output with iMode=1 -> oA=0, oB=0; oS_address follows iDec_addr during RUN_DEC.
//  5. iKey_req pulsed mid-RUN_ENC -> block completes and is delivered, then KEY_EXP; oReady=0 throughout.
//  6. Back-to-back blocks with iReady=1 -> oStart_enc low for >=1 cycle between blocks; rst low mid-run -> all 0.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared types and helpers for the RC5 scheduler slice.
// Optional feature macro: RC5_DECRYPT_EN (adds the RUN_DEC state and live decrypt path).
package rc5_pkg;

  // Scheduler state encoding; RUN_DEC exists only when the decrypt path is built.
  typedef enum logic [2:0] {
    NO_KEY  = 3'd0,
    KEY_EXP = 3'd1,
    READY   = 3'd2,
    RUN_ENC = 3'd3,
`ifdef RC5_DECRYPT_EN
    RUN_DEC = 3'd4,
`endif
    DONE    = 3'd5
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Number of words in the expanded key table for R rounds.
  function automatic int unsigned t_words(input int unsigned r);
    return 2 * (r + 1);
  endfunction

  // Address width needed to index the expanded key table.
  function automatic int unsigned t_length(input int unsigned r);
    return $clog2(t_words(r));
  endfunction

endpackage

// File: rtl/rc5_s_addr_mux.sv
// Selects which engine drives the shared S-table address pair.
// Optional feature macro: RC5_DECRYPT_EN (decrypt address pair selectable in RUN_DEC).
module rc5_s_addr_mux
  import rc5_pkg::*;
#(
  parameter int unsigned T_LENGTH = 5
) (
  input  state_t              i_state,
  input  logic [T_LENGTH-1:0] i_key_addr1,
  input  logic [T_LENGTH-1:0] i_key_addr2,
  input  logic [T_LENGTH-1:0] i_enc_addr1,
  input  logic [T_LENGTH-1:0] i_enc_addr2,
  input  logic [T_LENGTH-1:0] i_dec_addr1,
  input  logic [T_LENGTH-1:0] i_dec_addr2,
  output logic [T_LENGTH-1:0] o_addr1,
  output logic [T_LENGTH-1:0] o_addr2
);

  // Key engine owns the table during expansion, decrypt while decrypting, encrypt otherwise.
  always_comb begin
    o_addr1 = i_enc_addr1;
    o_addr2 = i_enc_addr2;
    case (i_state)
      KEY_EXP: begin
        o_addr1 = i_key_addr1;
        o_addr2 = i_key_addr2;
      end
`ifdef RC5_DECRYPT_EN
      RUN_DEC: begin
        o_addr1 = i_dec_addr1;
        o_addr2 = i_dec_addr2;
      end
`endif
      default: ;
    endcase
  end

`ifndef RC5_DECRYPT_EN
  logic w_dec_unused;
  assign w_dec_unused = ^{i_dec_addr1, i_dec_addr2};
`endif

endmodule

// File: rtl/rc5_scheduler.sv
// RC5 core sequencer: key expansion, block dispatch to the engines, result hand-off.
// Optional feature macro: RC5_DECRYPT_EN (honours iMode and drives the decrypt engine).
module rc5_scheduler
  import rc5_pkg::*;
#(
  parameter  int unsigned W        = 32,
  parameter  int unsigned R        = 12,
  localparam int unsigned T_LENGTH = t_length(R)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iKey_req,
  output logic                oKey_start,
  input  logic                iKey_done,
  output logic                oKey_valid,
  input  logic                iValid,
  output logic                oReady,
  input  logic                iMode,
  input  logic [W-1:0]        iA,
  input  logic [W-1:0]        iB,
  output logic [W-1:0]        oEng_A,
  output logic [W-1:0]        oEng_B,
  output logic                oStart_enc,
  output logic                oStart_dec,
  input  logic                iEnc_done,
  input  logic                iDec_done,
  input  logic [W-1:0]        iEnc_A,
  input  logic [W-1:0]        iEnc_B,
  input  logic [W-1:0]        iDec_A,
  input  logic [W-1:0]        iDec_B,
  input  logic [T_LENGTH-1:0] iKey_addr1,
  input  logic [T_LENGTH-1:0] iKey_addr2,
  input  logic [T_LENGTH-1:0] iEnc_addr1,
  input  logic [T_LENGTH-1:0] iEnc_addr2,
  input  logic [T_LENGTH-1:0] iDec_addr1,
  input  logic [T_LENGTH-1:0] iDec_addr2,
  output logic [T_LENGTH-1:0] oS_address1,
  output logic [T_LENGTH-1:0] oS_address2,
  output logic                oValid,
  input  logic                iReady,
  output logic [W-1:0]        oA,
  output logic [W-1:0]        oB
);

  state_t r_state;
  state_t w_next_state;

  logic r_key_pend, r_key_start, r_key_valid, r_ready, r_start_enc, r_valid;
  logic w_key_pend_nxt, w_key_valid_nxt;
  logic w_accept, w_cap_enc, w_busy;
  logic [W-1:0] r_eng_a, r_eng_b, r_a, r_b;
  logic [T_LENGTH-1:0] w_addr1, w_addr2;

`ifdef RC5_DECRYPT_EN
  logic r_start_dec;
  logic w_cap_dec;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= NO_KEY;
    else      r_state <= w_next_state;
  end

  // Next-state decode plus next values of the registered control outputs.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_cap_enc    = 1'b0;
`ifdef RC5_DECRYPT_EN
    w_cap_dec    = 1'b0;
`endif
    case (r_state)
      NO_KEY:  if (iKey_req)  w_next_state = KEY_EXP;
      KEY_EXP: if (iKey_done) w_next_state = READY;
      READY: begin
        // A key request in the same cycle as a block wins; the block is left waiting.
        if (iKey_req) begin
          w_next_state = KEY_EXP;
        end else if (iValid && r_ready) begin
          w_accept = 1'b1;
`ifdef RC5_DECRYPT_EN
          w_next_state = (iMode == MODE_DEC) ? RUN_DEC : RUN_ENC;
`else
          w_next_state = RUN_ENC;
`endif
        end
      end
      RUN_ENC: begin
        if (iEnc_done) begin
          w_cap_enc    = 1'b1;
          w_next_state = DONE;
        end
      end
`ifdef RC5_DECRYPT_EN
      RUN_DEC: begin
        if (iDec_done) begin
          w_cap_dec    = 1'b1;
          w_next_state = DONE;
        end
      end
`endif
      DONE: begin
        if (r_valid && iReady)
          w_next_state = (r_key_pend || iKey_req) ? KEY_EXP : READY;
      end
      default: w_next_state = NO_KEY;
    endcase

    w_busy = (r_state == RUN_ENC) || (r_state == DONE);
`ifdef RC5_DECRYPT_EN
    w_busy = w_busy || (r_state == RUN_DEC);
`endif

    // Key requests arriving while a block is in flight are remembered until expansion starts.
    w_key_pend_nxt = r_key_pend;
    if (w_next_state == KEY_EXP)  w_key_pend_nxt = 1'b0;
    else if (iKey_req && w_busy)  w_key_pend_nxt = 1'b1;

    w_key_valid_nxt = r_key_valid;
    if (w_next_state == KEY_EXP)                              w_key_valid_nxt = 1'b0;
    else if (r_state == KEY_EXP && w_next_state == READY)     w_key_valid_nxt = 1'b1;
  end

  // Control outputs registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_pend  <= 1'b0;
      r_key_start <= 1'b0;
      r_key_valid <= 1'b0;
      r_ready     <= 1'b0;
      r_start_enc <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_key_pend  <= w_key_pend_nxt;
      r_key_start <= (w_next_state == KEY_EXP);
      r_key_valid <= w_key_valid_nxt;
      r_ready     <= (w_next_state == READY) && !w_key_pend_nxt;
      r_start_enc <= (w_next_state == RUN_ENC);
      r_valid     <= (w_next_state == DONE);
    end
  end

`ifdef RC5_DECRYPT_EN
  // Decrypt engine start, high for exactly the RUN_DEC residency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_start_dec <= 1'b0;
    else      r_start_dec <= (w_next_state == RUN_DEC);
  end
  assign oStart_dec = r_start_dec;
`else
  assign oStart_dec = 1'b0;
  logic w_dec_unused;
  assign w_dec_unused = ^{iMode, iDec_done, iDec_A, iDec_B};
`endif

  // Engine operand capture on accept; held stable for the whole run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_eng_a <= '0;
      r_eng_b <= '0;
    end else if (w_accept) begin
      r_eng_a <= iA;
      r_eng_b <= iB;
    end
  end

  // Result capture from whichever engine just finished; held until accepted downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_cap_enc) begin
      r_a <= iEnc_A;
      r_b <= iEnc_B;
`ifdef RC5_DECRYPT_EN
    end else if (w_cap_dec) begin
      r_a <= iDec_A;
      r_b <= iDec_B;
`endif
    end
  end

  rc5_s_addr_mux #(
    .T_LENGTH (T_LENGTH)
  ) u_s_addr_mux (
    .i_state     (r_state),
    .i_key_addr1 (iKey_addr1),
    .i_key_addr2 (iKey_addr2),
    .i_enc_addr1 (iEnc_addr1),
    .i_enc_addr2 (iEnc_addr2),
    .i_dec_addr1 (iDec_addr1),
    .i_dec_addr2 (iDec_addr2),
    .o_addr1     (w_addr1),
    .o_addr2     (w_addr2)
  );

  // Table address is combinational; while reset is held it parks at {0,1}.
  assign oS_address1 = rst ? w_addr1 : T_LENGTH'(0);
  assign oS_address2 = rst ? w_addr2 : T_LENGTH'(1);

  assign oKey_start = r_key_start;
  assign oKey_valid = r_key_valid;
  assign oReady     = r_ready;
  assign oStart_enc = r_start_enc;
  assign oValid     = r_valid;
  assign oEng_A     = r_eng_a;
  assign oEng_B     = r_eng_b;
  assign oA         = r_a;
  assign oB         = r_b;

endmodule

// File: tb/tb_rc5_scheduler.sv
// Scoreboard bench for rc5_scheduler with behavioural RC5 engines.
// Honours RC5_DECRYPT_EN when defined.
module tb_rc5_scheduler;

  localparam int unsigned W    = 32;
  localparam int unsigned R    = 12;
  localparam int unsigned TW   = 2 * (R + 1);
  localparam int unsigned TL   = $clog2(TW);
  localparam int unsigned KLAT = 10;

  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic iKey_req = 1'b0, iKey_done = 1'b0, iValid = 1'b0, iMode = 1'b0, iReady = 1'b0;
  logic iEnc_done = 1'b0, iDec_done = 1'b0;
  logic [W-1:0] iA = '0, iB = '0, iEnc_A = '0, iEnc_B = '0, iDec_A = '0, iDec_B = '0;
  logic [TL-1:0] iKey_addr1 = '0, iKey_addr2 = '0, iEnc_addr1 = '0, iEnc_addr2 = '0;
  logic [TL-1:0] iDec_addr1 = '0, iDec_addr2 = '0;
  logic oKey_start, oKey_valid, oReady, oStart_enc, oStart_dec, oValid;
  logic [W-1:0] oEng_A, oEng_B, oA, oB;
  logic [TL-1:0] oS_address1, oS_address2;

  int checks = 0;
  int errors = 0;
  int hold_cycles = 0;
  blk_t sb[$];
  logic [W-1:0] s_tab [TW];

  rc5_scheduler #(.W(W), .R(R)) dut (
    .clk(clk), .rst(rst), .iKey_req(iKey_req), .oKey_start(oKey_start), .iKey_done(iKey_done),
    .oKey_valid(oKey_valid), .iValid(iValid), .oReady(oReady), .iMode(iMode), .iA(iA), .iB(iB),
    .oEng_A(oEng_A), .oEng_B(oEng_B), .oStart_enc(oStart_enc), .oStart_dec(oStart_dec),
    .iEnc_done(iEnc_done), .iDec_done(iDec_done), .iEnc_A(iEnc_A), .iEnc_B(iEnc_B),
    .iDec_A(iDec_A), .iDec_B(iDec_B), .iKey_addr1(iKey_addr1), .iKey_addr2(iKey_addr2),
    .iEnc_addr1(iEnc_addr1), .iEnc_addr2(iEnc_addr2), .iDec_addr1(iDec_addr1),
    .iDec_addr2(iDec_addr2), .oS_address1(oS_address1), .oS_address2(oS_address2),
    .oValid(oValid), .iReady(iReady), .oA(oA), .oB(oB)
  );

  always #5 clk = ~clk;

  // ---------------- reference RC5 model ----------------
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [W-1:0] s);
    int unsigned n;
    n = s % W;
    if (n == 0) return x;
    return (x << n) | (x >> (W - n));
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [W-1:0] s);
    return rotl(x, W - (s % W));
  endfunction

  task automatic expand_zero_key();
    logic [W-1:0] l [4];
    logic [W-1:0] a, b;
    int i, j;
    for (int k = 0; k < 4; k++) l[k] = '0;
    s_tab[0] = 32'hB7E15163;
    for (int k = 1; k < TW; k++) s_tab[k] = s_tab[k-1] + 32'h9E3779B9;
    a = '0; b = '0; i = 0; j = 0;
    for (int k = 0; k < 3 * TW; k++) begin
      a = rotl(s_tab[i] + a + b, 32'd3);
      s_tab[i] = a;
      b = rotl(l[j] + a + b, a + b);
      l[j] = b;
      i = (i + 1) % TW;
      j = (j + 1) % 4;
    end
  endtask

  function automatic blk_t rc5_enc(input blk_t p);
    logic [W-1:0] a, b;
    a = p.a + s_tab[0];
    b = p.b + s_tab[1];
    for (int i = 1; i <= R; i++) begin
      a = rotl(a ^ b, b) + s_tab[2*i];
      b = rotl(b ^ a, a) + s_tab[2*i+1];
    end
    return {a, b};
  endfunction

  function automatic blk_t rc5_dec(input blk_t p);
    logic [W-1:0] a, b;
    a = p.a;
    b = p.b;
    for (int i = R; i >= 1; i--) begin
      b = rotr(b - s_tab[2*i+1], a) ^ a;
      a = rotr(a - s_tab[2*i], b) ^ b;
    end
    return {a - s_tab[0], b - s_tab[1]};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check64({tag, "_ctrl"},
            64'({oKey_start, oKey_valid, oReady, oStart_enc, oStart_dec, oValid, oS_address1, oS_address2}),
            64'({6'b0, TL'(0), TL'(1)}));
    check64({tag, "_res"}, {oA, oB}, 64'(0));
    check64({tag, "_eng"}, {oEng_A, oEng_B}, 64'(0));
  endtask

  // ---------------- behavioural engines ----------------
  int kcnt = 0, ecnt = 0, elat = 1, dcnt = 0, dlat = 1;

  // Engines react on the falling edge so their outputs are stable at the next rising edge.
  always @(negedge clk) begin
    iKey_addr1 = TL'($urandom); iKey_addr2 = TL'($urandom);
    iEnc_addr1 = TL'($urandom); iEnc_addr2 = TL'($urandom);
    iDec_addr1 = TL'($urandom); iDec_addr2 = TL'($urandom);
    if (!rst) begin
      kcnt = 0; ecnt = 0; dcnt = 0;
      iKey_done = 1'b0; iEnc_done = 1'b0; iDec_done = 1'b0;
    end else begin
      if (oKey_start) begin
        kcnt++;
        iKey_done = (kcnt >= KLAT);
      end else begin
        kcnt = 0;
        iKey_done = ($urandom_range(0, 15) == 0);
      end
      if (oStart_enc) begin
        if (ecnt == 0) elat = $urandom_range(1, 8);
        ecnt++;
        iEnc_done = (ecnt >= elat);
        if (iEnc_done) {iEnc_A, iEnc_B} = rc5_enc({oEng_A, oEng_B});
        else begin iEnc_A = $urandom; iEnc_B = $urandom; end
      end else begin
        ecnt = 0;
        iEnc_done = ($urandom_range(0, 7) == 0);
        iEnc_A = $urandom; iEnc_B = $urandom;
      end
      if (oStart_dec) begin
        if (dcnt == 0) dlat = $urandom_range(1, 8);
        dcnt++;
        iDec_done = (dcnt >= dlat);
        if (iDec_done) {iDec_A, iDec_B} = rc5_dec({oEng_A, oEng_B});
        else begin iDec_A = $urandom; iDec_B = $urandom; end
      end else begin
        dcnt = 0;
        iDec_done = ($urandom_range(0, 7) == 0);
        iDec_A = $urandom; iDec_B = $urandom;
      end
    end
  end

  // ---------------- monitor ----------------
  logic pv_valid = 1'b0, pv_ready = 1'b0, pv_done = 1'b0, pv_kstart = 1'b0;
  logic [W-1:0] pv_a = '0, pv_b = '0;
  int kdur = 0;

  initial begin
    blk_t exp_blk;
    logic [2*TL-1:0] exp_addr;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        check_reset_outs("mon_reset");
        pv_valid = 1'b0; pv_ready = 1'b0; pv_done = 1'b0; pv_kstart = 1'b0; kdur = 0;
        iReady = 1'b0;
      end else begin
        exp_addr = oKey_start ? {iKey_addr1, iKey_addr2} :
                   oStart_dec ? {iDec_addr1, iDec_addr2} : {iEnc_addr1, iEnc_addr2};
        check64("s_addr", 64'({oS_address1, oS_address2}), 64'(exp_addr));
        check1("one_phase", $countones({oKey_start, oStart_enc, oStart_dec, oValid, oReady}) <= 1, 1'b1);
        if (oReady) check1("ready_needs_key", oKey_valid, 1'b1);
        if (pv_done) check1("done_to_valid", oValid, 1'b1);
        if (oKey_start) begin
          kdur++;
          check1("keyvalid_low_in_exp", oKey_valid, 1'b0);
        end else if (pv_kstart) begin
          check64("key_start_len", 64'(kdur), 64'(KLAT));
          check1("keyvalid_after_exp", oKey_valid, 1'b1);
          kdur = 0;
        end
        if (pv_valid && !pv_ready && oValid)
          check64("hold_ab", {oA, oB}, {pv_a, pv_b});
        if (oValid && hold_cycles > 0) begin
          iReady = 1'b0;
          hold_cycles--;
        end else begin
          iReady = ($urandom_range(0, 3) != 0);
        end
        if (oValid && iReady) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result actual=%h required=none", {oA, oB});
          end else begin
            exp_blk = sb.pop_front();
            check64("result", {oA, oB}, exp_blk);
          end
        end
        pv_done   = (oStart_enc && iEnc_done) || (oStart_dec && iDec_done);
        pv_valid  = oValid;
        pv_ready  = iReady;
        pv_a      = oA;
        pv_b      = oB;
        pv_kstart = oKey_start;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_block(input blk_t p, input logic mode, input logic has_exp, input blk_t exp_in);
    logic dm;
    logic acc;
    blk_t e;
    acc = 1'b0;
    dm  = 1'b0;
    @(posedge clk); #1;
    iValid = 1'b1; iA = p.a; iB = p.b; iMode = mode;
    for (int n = 0; n < 3000 && !acc; n++) begin
      @(negedge clk); #2;
      if (oReady && !iKey_req) begin
        acc = 1'b1;
`ifdef RC5_DECRYPT_EN
        dm = mode;
`endif
        e = has_exp ? exp_in : (dm ? rc5_dec(p) : rc5_enc(p));
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    iValid = 1'b0; iA = $urandom; iB = $urandom; iMode = 1'($urandom);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end else begin
      @(negedge clk); #2;
      check1("start_latency", dm ? oStart_dec : oStart_enc, 1'b1);
    end
  endtask

  task automatic wait_key_valid();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk); #2;
      ok = oKey_valid;
    end
    check1("key_valid_wait", ok, 1'b1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 2000 && sb.size() != 0; n++) begin
      @(negedge clk); #2;
    end
    check64("drain", 64'(sb.size()), 64'(0));
  endtask

  task automatic key_expand();
    @(posedge clk); #1; iKey_req = 1'b1;
    @(posedge clk); #1; iKey_req = 1'b0;
    @(negedge clk); #2;
    check1("key_start_rise", oKey_start, 1'b1);
    check1("key_valid_clear", oKey_valid, 1'b0);
    wait_key_valid();
  endtask

  // Key request at any point; block in flight must drain first and oReady stays low throughout.
  task automatic key_req_wait();
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1; iKey_req = 1'b1;
    @(posedge clk); #1; iKey_req = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk); #2;
      check1("pend_ready_low", oReady, 1'b0);
      if (oKey_start) begin
        seen = 1'b1;
        check64("pend_delivered_first", 64'(sb.size()), 64'(0));
      end
    end
    check1("pend_key_start_seen", seen, 1'b1);
    wait_key_valid();
  endtask

  initial begin
    blk_t p, z;
    logic m;
    z = '0;
    expand_zero_key();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // No key yet: requests are refused and nothing starts.
    iValid = 1'b1; iA = 32'h1; iB = 32'h2;
    repeat (5) begin
      @(negedge clk); #2;
      check1("nokey_ready", oReady, 1'b0);
      check1("nokey_keyvalid", oKey_valid, 1'b0);
      check1("nokey_start", oKey_start | oStart_enc | oStart_dec, 1'b0);
    end
    iValid = 1'b0;

    key_expand();

    // Known answer for the all-zero key and block, held under back-pressure.
    hold_cycles = 5;
    send_block(z, 1'b0, 1'b1, {32'hEEDBA521, 32'h6D8F4B15});
    wait_drain();

`ifdef RC5_DECRYPT_EN
    send_block({32'hEEDBA521, 32'h6D8F4B15}, 1'b1, 1'b1, z);
    wait_drain();
`endif

    // Key request while a block is running.
    p.a = $urandom; p.b = $urandom;
    send_block(p, 1'b0, 1'b0, z);
    key_req_wait();

    // Key request and block offered together in READY: key wins.
    @(posedge clk); #1;
    iValid = 1'b1; iKey_req = 1'b1; iA = $urandom; iB = $urandom; iMode = 1'b0;
    @(posedge clk); #1;
    iValid = 1'b0; iKey_req = 1'b0;
    @(negedge clk); #2;
    check1("race_key_start", oKey_start, 1'b1);
    check1("race_no_enc", oStart_enc | oStart_dec, 1'b0);
    wait_key_valid();

    // Randomised stream, including iMode=1 which the encrypt-only build must ignore.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) key_req_wait();
      p.a = $urandom; p.b = $urandom; m = 1'($urandom);
      send_block(p, m, 1'b0, z);
    end
    wait_drain();

    // Reset in the middle of a run.
    p.a = $urandom; p.b = $urandom;
    send_block(p, 1'b0, 1'b0, z);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_reset_outs("midrun_reset");
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) begin
      @(negedge clk); #2;
      check1("post_reset_ready", oReady, 1'b0);
      check1("post_reset_keyvalid", oKey_valid, 1'b0);
    end

    key_expand();
    for (int i = 0; i < 6; i++) begin
      p.a = $urandom; p.b = $urandom; m = 1'($urandom);
      send_block(p, m, 1'b0, z);
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
